dilithium_expand_a_scheduler: RTL and testbench
===============================================

DILITHIUM_EXPAND_A_SCHEDULER -- requirements
Module: dilithium_expand_a_scheduler

Interface
REQ-001 The block SHALL have parameter K, default 6, number of matrix rows.
REQ-002 The block SHALL have parameter L, default 5, number of matrix columns.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin expansion of the full K x L matrix.
- rho  in  256  public seed, sampled on an accepted start.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when all K*L entries are finished.
- init_rtr  out  1  request to the SHAKE128 stream-init unit (level, held until release).
- init_seed  out  256  seed to the stream-init unit, equal to the latched rho.
- init_nonce  out  16  nonce to the stream-init unit, equal to {row[7:0], col[7:0]}.
- init_rts  in  1  stream-init unit result ready (level).
- smp_req  out  1  request to the rejection sampler to squeeze and sample the current entry.
- smp_ack  in  1  sampler has accepted smp_req.
- smp_done  in  1  one-cycle pulse from the sampler when the entry is written.
- row  out  8  current row index i, 0..K-1.
- col  out  8  current column index j, 0..L-1.

Function
REQ-004 The block SHALL be an FSM with states IDLE, REQ, SAMPLE, WAIT_SMP, RELEASE, ADVANCE, DONE.
REQ-005 In IDLE with start=1, the block SHALL latch rho, clear row and col to 0 and go to REQ on the next cycle; busy SHALL be 1 in every state except IDLE.
REQ-006 Start SHALL be ignored in every state other than IDLE; rho changes after acceptance SHALL have no effect.
REQ-007 In REQ the block SHALL drive init_rtr=1 and stay until init_rts=1, then go to SAMPLE.
REQ-008 In SAMPLE the block SHALL hold init_rtr=1 and smp_req=1 until smp_ack=1, then go to WAIT_SMP; smp_req SHALL be 0 in all other states.
REQ-009 In WAIT_SMP the block SHALL hold init_rtr=1, so the stream-init state stays valid for the sampler, until smp_done=1, then go to RELEASE.
REQ-010 A smp_done arriving in the same cycle as smp_ack SHALL be captured, and the block SHALL go directly from SAMPLE to RELEASE.
REQ-011 In RELEASE the block SHALL drive init_rtr=0 and stay until init_rts=0, then go to ADVANCE.
REQ-012 In ADVANCE, when col<L-1, col SHALL increment and the FSM SHALL go to REQ.
REQ-013 In ADVANCE, when col=L-1 and row<K-1, col SHALL become 0, row SHALL increment and the FSM SHALL go to REQ.
REQ-014 In ADVANCE, when col=L-1 and row=K-1, the FSM SHALL go to DONE without changing the indices.
REQ-015 In DONE the block SHALL assert done=1 for exactly one cycle, then return to IDLE; row and col SHALL hold their last values.
REQ-016 init_nonce SHALL be combinational from row and col: nonce = row*256 + col, 16 bits, with no carry between bytes.
REQ-017 init_seed SHALL be the latched rho and SHALL be stable from the accepting cycle until the next accepted start.
REQ-018 init_rtr SHALL be 1 only in REQ, SAMPLE and WAIT_SMP, and SHALL never rise while init_rts=1.
REQ-019 Exactly K*L init_rtr rising edges and K*L smp_req/smp_ack handshakes SHALL occur per accepted start.
REQ-020 Spurious init_rts, smp_ack or smp_done in states that do not wait on them SHALL be ignored.
REQ-021 All outputs SHALL be registered or decoded from the registered state; there SHALL be no combinational path from inputs to init_rtr or smp_req.

Reset
REQ-022 On reset=1 at a clock edge, the FSM SHALL enter IDLE with busy=0, done=0, init_rtr=0, smp_req=0, row=0, col=0 and latched rho=0, regardless of the current state.
REQ-023 Reset mid-operation SHALL abandon the matrix without a done pulse, and the next start SHALL restart at (0,0).

Verification
REQ-024 Full run, K=6, L=5: start with rho=0x01..20, stream-init model has rts latency 3, sampler done latency 10 -> 30 nonces in order 0x0000,0x0001..0x0004,0x0100..0x0504, one done pulse, then busy=0.
REQ-025 Back-pressure: smp_ack delayed 7 cycles on entry (2,3) -> smp_req held 7 cycles, init_rtr stays 1, nonce stays 0x0203, no index skipped.
REQ-026 Same-cycle events: smp_ack and smp_done asserted together -> FSM goes SAMPLE to RELEASE with no hang, and init_rtr drops the next cycle.
REQ-027 Release ordering: init_rts held high 4 cycles after init_rtr falls -> ADVANCE waits, and the next init_rtr rises only after init_rts=0.
REQ-028 Start while busy, with a different rho -> ignored, init_seed unchanged, exactly 30 handshakes.
REQ-029 Reset asserted during WAIT_SMP of entry (3,1) -> all outputs at reset values the next cycle, no done; a new start begins at nonce 0x0000.

Source files
------------

// File: rtl/dilithium_expand_a_scheduler.sv
// Walks the K x L matrix A of Dilithium ExpandA: for every (row, col) it opens a
// SHAKE128 stream, lets the rejection sampler fill the entry, then releases the stream.
module dilithium_expand_a_scheduler #(
    parameter int K = 6,
    parameter int L = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] rho,
    output logic         busy,
    output logic         done,
    output logic         init_rtr,
    output logic [255:0] init_seed,
    output logic [15:0]  init_nonce,
    input  logic         init_rts,
    output logic         smp_req,
    input  logic         smp_ack,
    input  logic         smp_done,
    output logic [7:0]   row,
    output logic [7:0]   col
);

    typedef enum logic [2:0] {
        IDLE, REQ, SAMPLE, WAIT_SMP, RELEASE, ADVANCE, DONE
    } state_t;

    localparam logic [7:0] LAST_ROW = 8'(K - 1);
    localparam logic [7:0] LAST_COL = 8'(L - 1);

    state_t       state, state_nxt;
    logic [7:0]   row_nxt, col_nxt;
    logic [255:0] seed_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            init_seed <= '0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            init_seed <= seed_nxt;
        end
    end

    // All handshake outputs decode from the state register only, so nothing
    // from the input pins reaches init_rtr or smp_req in the same cycle.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        seed_nxt  = init_seed;
        busy      = (state != IDLE);
        done      = 1'b0;
        init_rtr  = 1'b0;
        smp_req   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    seed_nxt  = rho;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                init_rtr = 1'b1;
                if (init_rts) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                init_rtr = 1'b1;
                smp_req  = 1'b1;
                // The sampler may finish in the very cycle it accepts.
                if (smp_ack) state_nxt = smp_done ? RELEASE : WAIT_SMP;
            end
            WAIT_SMP: begin
                init_rtr = 1'b1;
                if (smp_done) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!init_rts) state_nxt = ADVANCE;
            end
            ADVANCE: begin
                if (col < LAST_COL) begin
                    col_nxt   = col + 8'd1;
                    state_nxt = REQ;
                end else if (row < LAST_ROW) begin
                    col_nxt   = '0;
                    row_nxt   = row + 8'd1;
                    state_nxt = REQ;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign init_nonce = {row, col};

endmodule

// File: tb/tb_dilithium_expand_a_scheduler.sv
// Bench for dilithium_expand_a_scheduler: stream-init and sampler responders,
// a nonce scoreboard, a table of timing scenarios and a mid-run reset sequence.
module tb_dilithium_expand_a_scheduler;

    localparam int K = 6;
    localparam int L = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [255:0] rho = '0;
    logic         busy, done, init_rtr, smp_req;
    logic [255:0] init_seed;
    logic [15:0]  init_nonce;
    logic         init_rts = 1'b0;
    logic         smp_ack = 1'b0;
    logic         smp_done = 1'b0;
    logic [7:0]   row, col;

    dilithium_expand_a_scheduler #(.K(K), .L(L)) dut (
        .clock(clock), .reset(reset), .start(start), .rho(rho),
        .busy(busy), .done(done), .init_rtr(init_rtr), .init_seed(init_seed),
        .init_nonce(init_nonce), .init_rts(init_rts), .smp_req(smp_req),
        .smp_ack(smp_ack), .smp_done(smp_done), .row(row), .col(col)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_seed(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Responder configuration and observation counters
    int  cfg_rts_lat = 3, cfg_ack_dly = 1, cfg_done_dly = 10, cfg_rel_hold = 0;
    bit  cfg_bp = 0;
    int  n_hs, n_rise, n_done;
    int  up_cnt, rel_cnt, req_cycles, req_need, done_wait;
    bit  done_pend, same_chk, prev_rtr;
    logic [15:0] held_nonce, last_nonce;
    logic [15:0] sb[$];

    always @(negedge clock) begin
        if (reset) begin
            init_rts = 0; smp_ack = 0; smp_done = 0;
            up_cnt = 0; rel_cnt = 0; req_cycles = 0; done_wait = 0;
            done_pend = 0; same_chk = 0; prev_rtr = 0;
            sb.delete();
        end else begin
            if (done) n_done++;
            if (init_rtr && !prev_rtr) begin
                n_rise++;
                chk("rtr_rise_while_rts", int'(init_rts), 0);
            end
            prev_rtr = init_rtr;
            // stream-init unit
            if (init_rtr) begin
                rel_cnt = 0;
                if (up_cnt < cfg_rts_lat) up_cnt++;
                else init_rts = 1;
            end else begin
                up_cnt = 0;
                if (init_rts) begin
                    if (rel_cnt < cfg_rel_hold) rel_cnt++;
                    else init_rts = 0;
                end
            end
            // rejection sampler
            smp_ack = 0;
            smp_done = 0;
            if (done_pend) begin
                done_wait--;
                if (done_wait <= 0) begin
                    smp_done = 1;
                    done_pend = 0;
                end
            end
            if (smp_req) begin
                if (req_cycles == 0) held_nonce = init_nonce;
                else chk("nonce_stable", int'(init_nonce), int'(held_nonce));
                chk("rtr_during_req", int'(init_rtr), 1);
                req_cycles++;
                req_need = (cfg_bp && init_nonce == 16'h0203) ? 7 : cfg_ack_dly;
                if (req_cycles >= req_need) begin
                    smp_ack = 1;
                    n_hs++;
                    if (sb.size() == 0) chk("sb_underflow", int'(init_nonce), -1);
                    else chk("nonce_order", int'(init_nonce), int'(sb.pop_front()));
                    last_nonce = init_nonce;
                    if (cfg_done_dly == 0) begin
                        smp_done = 1;
                        same_chk = 1;
                    end else begin
                        done_pend = 1;
                        done_wait = cfg_done_dly;
                    end
                end
            end else if (req_cycles != 0) begin
                chk("req_hold_cycles", req_cycles, req_need);
                req_cycles = 0;
                if (same_chk) begin
                    chk("same_cycle_rtr_drop", int'(init_rtr), 0);
                    same_chk = 0;
                end
            end
        end
    end

    task automatic push_all();
        for (int i = 0; i < K; i++)
            for (int j = 0; j < L; j++)
                sb.push_back({8'(i), 8'(j)});
    endtask

    task automatic run_matrix(input logic [255:0] r, input bit mid_start,
                              input logic [255:0] r2, input int exp_hs);
        int cyc;
        bit seen;
        n_hs = 0; n_rise = 0; n_done = 0;
        push_all();
        start = 1; rho = r;
        @(negedge clock);
        start = 0; rho = r2;
        cyc = 0; seen = 0;
        while (!seen && cyc < 4000) begin
            start = (mid_start && cyc == 60);
            @(negedge clock);
            cyc++;
            if (done) seen = 1;
        end
        start = 0;
        chk("done_seen", int'(seen), 1);
        chk("busy_at_done", int'(busy), 1);
        chk("row_final", int'(row), K - 1);
        chk("col_final", int'(col), L - 1);
        @(negedge clock);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        chk("row_hold", int'(row), K - 1);
        chk("handshakes", n_hs, exp_hs);
        chk("rtr_rises", n_rise, exp_hs);
        chk("sb_empty", sb.size(), 0);
        chk("done_pulses", n_done, 1);
        chk_seed("seed_latched", init_seed, r);
    endtask

    typedef struct {
        int rts_lat; int ack_dly; int done_dly; int rel_hold;
        bit bp; bit mid; int exp_hs;
    } vec_t;

    vec_t vecs[5];
    logic [255:0] rho0;

    initial begin
        int cyc;
        vecs[0] = '{3, 1, 10, 0, 0, 0, K * L};  // baseline full run
        vecs[1] = '{2, 1, 0,  0, 0, 0, K * L};  // ack and done together
        vecs[2] = '{3, 2, 4,  4, 0, 0, K * L};  // rts lingers after release
        vecs[3] = '{1, 1, 3,  0, 1, 0, K * L};  // back-pressure on (2,3)
        vecs[4] = '{3, 1, 10, 0, 0, 1, K * L};  // start while busy
        for (int i = 0; i < 32; i++) rho0[255 - 8 * i -: 8] = 8'(i + 1);

        @(negedge clock);
        @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rtr", int'(init_rtr), 0);
        chk("rst_req", int'(smp_req), 0);
        chk("rst_nonce", int'(init_nonce), 0);
        chk_seed("rst_seed", init_seed, '0);
        reset = 0;
        @(negedge clock);
        chk("idle_busy", int'(busy), 0);

        for (int v = 0; v < 5; v++) begin
            cfg_rts_lat = vecs[v].rts_lat;
            cfg_ack_dly = vecs[v].ack_dly;
            cfg_done_dly = vecs[v].done_dly;
            cfg_rel_hold = vecs[v].rel_hold;
            cfg_bp = vecs[v].bp;
            run_matrix(rho0 + 256'(v), vecs[v].mid, ~rho0, vecs[v].exp_hs);
            @(negedge clock);
        end

        // Reset while the sampler works on entry (3,1)
        cfg_rts_lat = 3; cfg_ack_dly = 1; cfg_done_dly = 10; cfg_rel_hold = 0; cfg_bp = 0;
        n_done = 0;
        last_nonce = '0;
        push_all();
        start = 1; rho = rho0;
        @(negedge clock);
        start = 0;
        cyc = 0;
        while (!(done_pend && last_nonce == 16'h0301) && cyc < 4000) begin
            @(negedge clock);
            cyc++;
        end
        chk("reach_3_1", int'(last_nonce), 16'h0301);
        @(negedge clock);
        chk("pre_reset_rtr", int'(init_rtr), 1);
        chk("pre_reset_nonce", int'(init_nonce), 16'h0301);
        reset = 1;
        @(negedge clock);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_rtr", int'(init_rtr), 0);
        chk("mid_rst_req", int'(smp_req), 0);
        chk("mid_rst_row", int'(row), 0);
        chk("mid_rst_col", int'(col), 0);
        chk_seed("mid_rst_seed", init_seed, '0);
        reset = 0;
        repeat (20) @(negedge clock);
        chk("no_done_after_reset", n_done, 0);
        chk("idle_after_reset", int'(busy), 0);
        run_matrix(rho0 ^ {8{32'h5a5a_0f0f}}, 0, rho0, K * L);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
